// File: rtl/selector_color_rgb.sv
// Button/switch front end for the VGA controller: synchronises raw inputs, debounces
// the two step buttons and produces the registered 3-bit colour code ctrl_rgb.

module selector_color_rgb_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic CLK,
  input  logic RESET,
  input  logic b_i,
  output logic press_o
);

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_WAIT_PRESS   = 3'd1;
  localparam logic [2:0] ST_PRESSED      = 3'd2;
  localparam logic [2:0] ST_HELD         = 3'd3;
  localparam logic [2:0] ST_WAIT_RELEASE = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only advances below CNT_LAST, so it saturates instead of wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (b_i) begin
          state_d = ST_WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      ST_WAIT_PRESS: begin
        if (!b_i)                  state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST) state_d = ST_PRESSED;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_PRESSED: state_d = ST_HELD;
      ST_HELD: begin
        if (!b_i) begin
          state_d = ST_WAIT_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_WAIT_RELEASE: begin
        if (b_i)                    state_d = ST_HELD;
        else if (cnt_q == CNT_LAST) state_d = ST_IDLE;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = (state_q == ST_PRESSED);

endmodule

module selector_color_rgb #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       sw_manual,
  input  logic [2:0] sw_rgb,
  output logic [2:0] ctrl_rgb,
  output logic       press_next,
  output logic       press_prev
);

  // Bit order: [0]=btn_next, [1]=btn_prev, [2]=sw_manual, [5:3]=sw_rgb.
  logic [5:0] raw;
  logic [5:0] sync1_q, sync2_q;
  logic [1:0] press;
  logic [2:0] index_q, index_d;
  logic [2:0] ctrl_rgb_q, ctrl_rgb_d;

  assign raw = {sw_rgb, sw_manual, btn_prev, btn_next};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      selector_color_rgb_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_debounce (
        .CLK    (CLK),
        .RESET  (RESET),
        .b_i    (sync2_q[gi]),
        .press_o(press[gi])
      );
    end
  endgenerate

  // Simultaneous next/prev presses cancel out.
  always_comb begin
    index_d = index_q;
    case (press)
      2'b01:   index_d = index_q + 3'd1;
      2'b10:   index_d = index_q - 3'd1;
      default: index_d = index_q;
    endcase
  end

  assign ctrl_rgb_d = sync2_q[2] ? sync2_q[5:3] : index_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      index_q    <= '0;
      ctrl_rgb_q <= '0;
    end else begin
      index_q    <= index_d;
      ctrl_rgb_q <= ctrl_rgb_d;
    end
  end

  assign ctrl_rgb   = ctrl_rgb_q;
  assign press_next = press[0];
  assign press_prev = press[1];

endmodule
